ped64_cfg_frame_rx: RTL and testbench

Byte-stream configuration frame receiver feeding the ped64 core's uplink configuration port. It hunts for a header byte, captures a length-prefixed payload of 64-bit config words into an internal buffer, and checks an XOR checksum. Only checksum-clean frames are replayed to ped64 as addressed 64-bit words over a valid/ready interface. It sits between the uplink config source and ped64.

---
 rtl/ped64_cfg_frame_rx.sv | 204 ++++++++++++++++++++
 tb/tb_ped64_cfg_frame_rx.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ped64_cfg_frame_rx.sv
// ped64 uplink config frame receiver: HDR/LEN/payload/XOR-CSUM in, 64-bit words out.
// Optional inter-byte timeout enabled by defining PED64_CFG_TIMEOUT_EN.
module ped64_cfg_frame_rx #(
  parameter int          MAX_WORDS = 16,
  parameter logic [7:0]  HDR       = 8'hA5,
  parameter int          TIMEOUT   = 1024,
  localparam int         AW        = $clog2(MAX_WORDS)
) (
  input  logic          gm_clk,
  input  logic          rst_n,
  input  logic [7:0]    s_data,
  input  logic          s_valid,
  output logic          s_ready,
  output logic [63:0]   m_data,
  output logic [AW-1:0] m_addr,
  output logic          m_valid,
  input  logic          m_ready,
  output logic          frame_done,
  output logic          err_crc,
  output logic          err_len,
  output logic          err_timeout,
  output logic [15:0]   frame_cnt
);

  localparam int LW = $clog2(MAX_WORDS + 1);
  localparam int BW = LW + 3;

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_PAY, S_CSUM, S_EMIT
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [LW-1:0] r_len;
  logic [BW-1:0] r_bcnt;
  logic [7:0]    r_xor;
  logic [AW-1:0] r_idx;
  logic [63:0]   r_buf [MAX_WORDS];
  logic          r_done;
  logic          r_crc;
  logic          r_lenerr;
  logic          r_tmo;
  logic [15:0]   r_cnt;

  logic w_acc;
  logic w_xfer;
  logic w_len_bad;
  logic w_last_byte;
  logic w_last_word;
  logic w_tmo;
  logic w_pl_done;
  logic w_pl_crc;
  logic w_pl_len;

  assign w_acc       = s_valid && s_ready;
  assign w_xfer      = m_valid && m_ready;
  assign w_len_bad   = (s_data == 8'd0) ||
                       (s_data > 8'(MAX_WORDS));
  assign w_last_byte = r_bcnt == ({r_len, 3'b000} - BW'(1));
  assign w_last_word = LW'(r_idx) == (r_len - LW'(1));

`ifdef PED64_CFG_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] r_gap;
  logic          w_in_frame;

  assign w_in_frame = (r_state == S_LEN) ||
                      (r_state == S_PAY) ||
                      (r_state == S_CSUM);
  assign w_tmo = w_in_frame && !w_acc &&
                 (r_gap == TW'(TIMEOUT - 1));

  // gap counter: idle cycles since the last accepted frame byte
  always_ff @(posedge gm_clk) begin
    if (!rst_n)
      r_gap <= '0;
    else if (w_acc || !w_in_frame)
      r_gap <= '0;
    else
      r_gap <= r_gap + TW'(1);
  end
`else
  assign w_tmo = 1'b0;
`endif

  // state register
  always_ff @(posedge gm_clk) begin
    if (!rst_n)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  // next-state and event decode
  always_comb begin
    w_next    = r_state;
    w_pl_done = 1'b0;
    w_pl_crc  = 1'b0;
    w_pl_len  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_acc && s_data == HDR)
          w_next = S_LEN;
      end
      S_LEN: begin
        if (w_acc) begin
          if (w_len_bad) begin
            w_pl_len = 1'b1;
            w_next   = S_IDLE;
          end else begin
            w_next = S_PAY;
          end
        end
      end
      S_PAY: begin
        if (w_acc && w_last_byte)
          w_next = S_CSUM;
      end
      S_CSUM: begin
        if (w_acc) begin
          if (s_data == r_xor) begin
            w_next = S_EMIT;
          end else begin
            w_pl_crc = 1'b1;
            w_next   = S_IDLE;
          end
        end
      end
      S_EMIT: begin
        if (w_xfer && w_last_word) begin
          w_pl_done = 1'b1;
          w_next    = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
    if (w_tmo)
      w_next = S_IDLE;
  end

  // outputs decoded from registered state only
  always_comb begin
    s_ready = 1'b0;
    m_valid = 1'b0;
    m_data  = '0;
    m_addr  = '0;
    if (rst_n) begin
      s_ready = r_state != S_EMIT;
      if (r_state == S_EMIT) begin
        m_valid = 1'b1;
        m_data  = r_buf[r_idx];
        m_addr  = r_idx;
      end
    end
  end

  // frame bookkeeping, running checksum and event pulses
  always_ff @(posedge gm_clk) begin
    if (!rst_n) begin
      r_len    <= '0;
      r_bcnt   <= '0;
      r_xor    <= '0;
      r_idx    <= '0;
      r_done   <= 1'b0;
      r_crc    <= 1'b0;
      r_lenerr <= 1'b0;
      r_tmo    <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_done   <= w_pl_done;
      r_crc    <= w_pl_crc;
      r_lenerr <= w_pl_len;
      r_tmo    <= w_tmo;
      if (r_state == S_LEN && w_acc) begin
        r_len  <= s_data[LW-1:0];
        r_xor  <= s_data;
        r_bcnt <= '0;
      end
      if (r_state == S_PAY && w_acc) begin
        r_xor  <= r_xor ^ s_data;
        r_bcnt <= r_bcnt + BW'(1);
      end
      if (r_state == S_CSUM)
        r_idx <= '0;
      else if (w_xfer)
        r_idx <= r_idx + AW'(1);
      if (w_pl_done)
        r_cnt <= r_cnt + 16'd1;
    end
  end

  // payload buffer: little-endian byte packing
  always_ff @(posedge gm_clk) begin
    if (r_state == S_PAY && w_acc)
      r_buf[r_bcnt[AW+2:3]][r_bcnt[2:0]*8 +: 8] <= s_data;
  end

  assign frame_done  = r_done;
  assign err_crc     = r_crc;
  assign err_len     = r_lenerr;
  assign err_timeout = r_tmo;
  assign frame_cnt   = r_cnt;

endmodule

// File: tb/tb_ped64_cfg_frame_rx.sv
// Scoreboard bench for ped64_cfg_frame_rx.
// Words and event pulses are queued by stimulus and popped by a monitor.
module tb_ped64_cfg_frame_rx;

  localparam logic [3:0] EV_DONE = 4'b1000;
  localparam logic [3:0] EV_CRC  = 4'b0100;
  localparam logic [3:0] EV_LEN  = 4'b0010;
  localparam logic [3:0] EV_TMO  = 4'b0001;

  logic        gm_clk = 1'b0;
  logic        rst_n;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_ready;
  logic [63:0] m_data;
  logic [3:0]  m_addr;
  logic        m_valid;
  logic        m_ready;
  logic        frame_done;
  logic        err_crc;
  logic        err_len;
  logic        err_timeout;
  logic [15:0] frame_cnt;

  int errors = 0;
  int checks = 0;
  int exp_cnt = 0;

  logic [67:0] exp_w  [$];
  logic [3:0]  exp_ev [$];
  logic [7:0]  fb     [$];

  logic        st_flag = 1'b0;
  logic [67:0] st_prev;

  ped64_cfg_frame_rx dut (
    .gm_clk      (gm_clk),
    .rst_n       (rst_n),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .m_data      (m_data),
    .m_addr      (m_addr),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .frame_done  (frame_done),
    .err_crc     (err_crc),
    .err_len     (err_len),
    .err_timeout (err_timeout),
    .frame_cnt   (frame_cnt)
  );

  always #5 gm_clk = ~gm_clk;

  task automatic chk(input string nm,
                     input logic [67:0] act,
                     input logic [67:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  // monitor: pops scoreboard on every word and pulse
  always @(negedge gm_clk) begin
    logic [3:0] code;
    code = {frame_done, err_crc, err_len, err_timeout};
    if (m_valid === 1'b1) begin
      chk("sready_in_emit", 68'(s_ready), 68'd0);
      if (st_flag)
        chk("bp_stable", {m_addr, m_data}, st_prev);
    end
    st_flag = (m_valid === 1'b1) && !m_ready;
    st_prev = {m_addr, m_data};
    if (m_valid === 1'b1 && m_ready) begin
      if (exp_w.size() == 0)
        chk("unexpected_word", {m_addr, m_data}, 68'd0);
      else
        chk("word", {m_addr, m_data}, exp_w.pop_front());
    end
    if ((|code) === 1'b1) begin
      if (exp_ev.size() == 0)
        chk("unexpected_event", 68'(code), 68'd0);
      else
        chk("event", 68'(code), 68'(exp_ev.pop_front()));
    end
  end

  task automatic send(input logic [7:0] b);
    int n = 0;
    s_data  = b;
    s_valid = 1'b1;
    while (s_ready !== 1'b1 && n < 300) begin
      @(posedge gm_clk); #1;
      n++;
    end
    if (n >= 300)
      chk("send_timeout", 68'(n), 68'd0);
    @(posedge gm_clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic send_fb(input int from);
    for (int i = from; i < fb.size(); i++)
      send(fb[i]);
  endtask

  task automatic build(input int len,
                       input logic [7:0] base,
                       input bit bad);
    logic [7:0]  x;
    logic [7:0]  b;
    logic [63:0] w;
    fb.delete();
    fb.push_back(8'hA5);
    fb.push_back(8'(len));
    x = 8'(len);
    for (int k = 0; k < len; k++) begin
      w = '0;
      for (int j = 0; j < 8; j++) begin
        b = base + 8'(k * 8 + j);
        x ^= b;
        w[j*8 +: 8] = b;
        fb.push_back(b);
      end
      if (!bad)
        exp_w.push_back({4'(k), w});
    end
    fb.push_back(bad ? (x ^ 8'hFF) : x);
    if (bad) begin
      exp_ev.push_back(EV_CRC);
    end else begin
      exp_ev.push_back(EV_DONE);
      exp_cnt++;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_w.size() != 0 || exp_ev.size() != 0)
           && n < 3000) begin
      @(posedge gm_clk); #1;
      n++;
    end
    if (n >= 3000)
      chk("wait_idle_budget", 68'(n), 68'd0);
    repeat (2) @(posedge gm_clk);
    #1;
  endtask

  initial begin
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_data  = 8'h00;
    m_ready = 1'b1;
    repeat (2) @(posedge gm_clk);
    #1;
    chk("rst_sready", 68'(s_ready), 68'd0);
    chk("rst_mvalid", 68'(m_valid), 68'd0);
    chk("rst_mdata", {m_addr, m_data}, 68'd0);
    chk("rst_pulses",
        68'({frame_done, err_crc, err_len, err_timeout}),
        68'd0);
    chk("rst_cnt", 68'(frame_cnt), 68'd0);
    rst_n = 1'b1;
    #1;
    chk("idle_sready", 68'(s_ready), 68'd1);

    // garbage then the reference good frame
    send(8'h00); send(8'hFF); send(8'h5A);
    exp_w.push_back({4'd0, 64'h0807060504030201});
    exp_ev.push_back(EV_DONE);
    exp_cnt++;
    send(8'hA5); send(8'h01);
    for (int i = 1; i <= 8; i++) send(8'(i));
    send(8'h09);
    wait_idle();
    chk("cnt_good1", 68'(frame_cnt), 68'd1);

    // bad checksum, then a good frame
    exp_ev.push_back(EV_CRC);
    send(8'hA5); send(8'h01);
    for (int i = 1; i <= 8; i++) send(8'(i));
    send(8'h00);
    wait_idle();
    chk("cnt_after_crc", 68'(frame_cnt), 68'd1);
    build(3, 8'h10, 1'b0);
    send_fb(0);
    wait_idle();
    chk("cnt_good2", 68'(frame_cnt), 68'(exp_cnt));
    build(1, 8'h77, 1'b1);
    send_fb(0);
    wait_idle();

    // illegal lengths
    exp_ev.push_back(EV_LEN);
    send(8'hA5); send(8'h00);
    build(1, 8'hA0, 1'b0);
    send_fb(0);
    wait_idle();
    exp_ev.push_back(EV_LEN);
    send(8'hA5); send(8'h11);
    send(8'h33);
    build(16, 8'hC0, 1'b0);
    send_fb(0);
    wait_idle();
    chk("cnt_after_len", 68'(frame_cnt), 68'(exp_cnt));

    // backpressure
    m_ready = 1'b0;
    build(2, 8'h50, 1'b0);
    send_fb(0);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 68'(m_valid), 68'd1);
      chk("bp_addr", 68'(m_addr), 68'd0);
      chk("bp_sready", 68'(s_ready), 68'd0);
      @(posedge gm_clk); #1;
    end
    m_ready = 1'b1;
    @(posedge gm_clk); #1;
    chk("bp_w1_valid", 68'(m_valid), 68'd1);
    chk("bp_w1_addr", 68'(m_addr), 68'd1);
    @(posedge gm_clk); #1;
    chk("bp_end_valid", 68'(m_valid), 68'd0);
    wait_idle();
    chk("cnt_bp", 68'(frame_cnt), 68'(exp_cnt));

`ifdef PED64_CFG_TIMEOUT_EN
    exp_ev.push_back(EV_TMO);
    send(8'hA5); send(8'h02);
    repeat (1024) @(posedge gm_clk);
    #1;
    wait_idle();
    chk("tmo_idle", 68'(s_ready), 68'd1);
    build(2, 8'h60, 1'b0);
    send_fb(0);
    wait_idle();
    build(2, 8'h40, 1'b0);
    send(fb[0]); send(fb[1]);
    repeat (1023) @(posedge gm_clk);
    #1;
    send_fb(2);
    wait_idle();
`else
    chk("tmo_tied", 68'(err_timeout), 68'd0);
    build(2, 8'h40, 1'b0);
    send(fb[0]); send(fb[1]);
    repeat (1100) @(posedge gm_clk);
    #1;
    send_fb(2);
    wait_idle();
`endif
    chk("cnt_stall", 68'(frame_cnt), 68'(exp_cnt));

    // reset mid-payload
    send(8'hA5); send(8'h02);
    for (int i = 0; i < 5; i++) send(8'(i));
    rst_n = 1'b0;
    @(posedge gm_clk); #1;
    chk("mid_rst_sready", 68'(s_ready), 68'd0);
    chk("mid_rst_mvalid", 68'(m_valid), 68'd0);
    chk("mid_rst_cnt", 68'(frame_cnt), 68'd0);
    chk("mid_rst_pulses",
        68'({frame_done, err_crc, err_len, err_timeout}),
        68'd0);
    rst_n = 1'b1;
    exp_cnt = 0;
    @(posedge gm_clk); #1;
    chk("post_rst_sready", 68'(s_ready), 68'd1);
    build(1, 8'h01, 1'b0);
    send_fb(0);
    wait_idle();
    chk("cnt_post_rst", 68'(frame_cnt), 68'd1);

    chk("words_left", 68'(exp_w.size()), 68'd0);
    chk("events_left", 68'(exp_ev.size()), 68'd0);
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
